// File: rtl/ofdm_pkg.sv
// Shared definitions for the OFDM receive path: MCP3002 frame geometry,
// command bits and the sampler state encoding.
package ofdm_pkg;

  localparam int unsigned MCP3002_FRAME_BITS = 15;
  localparam int unsigned MCP3002_DATA_BITS  = 10;
  localparam int unsigned MCP3002_NULL_IDX   = 4;

  localparam logic MCP3002_START_BIT = 1'b1;
  localparam logic MCP3002_SGL_BIT   = 1'b1;
  localparam logic MCP3002_MSBF_BIT  = 1'b1;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} mcp3002_state_t;

  // Command word, MSB first: start, SGL, ODD/SIGN (channel), MSBF.
  function automatic logic mcp3002_cmd_bit(input int unsigned idx, input logic channel);
    case (idx)
      0:       return MCP3002_START_BIT;
      1:       return MCP3002_SGL_BIT;
      2:       return channel;
      3:       return MCP3002_MSBF_BIT;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mcp3002_sampler_tick_gen.sv
// Free-running period timer: one-cycle tick each time the 0..PERIOD-1
// counter wraps, so the first tick lands PERIOD cycles after reset release.
module tick_gen #(
  parameter int unsigned PERIOD = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= wrap;
      cnt  <= wrap ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mcp3002_sampler.sv
// MCP3002 single-ended sampler: periodic conversion, SPI pin generation and
// 10-bit deserialisation, delivering each sample as a one-cycle valid pulse.
module mcp3002_sampler
  import ofdm_pkg::*;
#(
  parameter int unsigned CLK_FREQ          = 48_000_000,
  parameter int unsigned MCP3002_CLK_FREQ  = 800_000,
  parameter int unsigned ADC_SAMPLING_FREQ = 48_000,
  parameter int unsigned CHANNEL           = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         adc_dout,
  output logic                         adc_clk,
  output logic                         adc_din,
  output logic                         adc_cs,
  output logic [MCP3002_DATA_BITS-1:0] sample_data,
  output logic                         sample_valid,
  output logic                         overrun
);

  localparam int unsigned HALF   = CLK_FREQ / (2 * MCP3002_CLK_FREQ);
  localparam int unsigned PERIOD = CLK_FREQ / ADC_SAMPLING_FREQ;
  localparam int unsigned HW     = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned KW     = $clog2(MCP3002_FRAME_BITS);
  localparam logic        CH_BIT = (CHANNEL != 0);

  mcp3002_state_t state, state_nx;
  logic [HW-1:0]  hcnt, hcnt_nx;
  logic [KW-1:0]  k, k_nx;
  logic           sck_nx, din_nx, cs_nx, valid_nx;
  logic           dout_r;
  logic           tick;
  logic           half_done;
  logic [MCP3002_DATA_BITS-1:0] shreg, shreg_nx, data_nx;

  tick_gen #(.PERIOD(PERIOD)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign half_done = (hcnt == HW'(HALF - 1));
  assign overrun   = tick && (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      hcnt         <= '0;
      k            <= '0;
      adc_clk      <= 1'b0;
      adc_din      <= 1'b0;
      adc_cs       <= 1'b1;
      shreg        <= '0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      dout_r       <= 1'b0;
    end else begin
      state        <= state_nx;
      hcnt         <= hcnt_nx;
      k            <= k_nx;
      adc_clk      <= sck_nx;
      adc_din      <= din_nx;
      adc_cs       <= cs_nx;
      shreg        <= shreg_nx;
      sample_data  <= data_nx;
      sample_valid <= valid_nx;
      dout_r       <= adc_dout;
    end
  end

  always_comb begin
    state_nx = state;
    hcnt_nx  = half_done ? '0 : hcnt + HW'(1);
    k_nx     = k;
    sck_nx   = adc_clk;
    din_nx   = adc_din;
    cs_nx    = adc_cs;
    shreg_nx = shreg;
    data_nx  = sample_data;
    valid_nx = 1'b0;

    case (state)
      IDLE: begin
        hcnt_nx = '0;
        if (tick) begin
          state_nx = SETUP;
          cs_nx    = 1'b0;
          sck_nx   = 1'b0;
          din_nx   = mcp3002_cmd_bit(0, CH_BIT);
        end
      end
      SETUP: begin
        if (half_done) begin
          state_nx = SHIFT;
          k_nx     = '0;
          sck_nx   = 1'b1;
        end
      end
      SHIFT: begin
        // adc_clk itself marks which half of SCK period k is ending.
        if (half_done) begin
          if (adc_clk) begin
            sck_nx = 1'b0;
            din_nx = (k < KW'(3)) ? mcp3002_cmd_bit(32'(k) + 32'd1, CH_BIT) : 1'b0;
          end else if (k == KW'(MCP3002_FRAME_BITS - 1)) begin
            state_nx = HOLD;
            cs_nx    = 1'b1;
            din_nx   = 1'b0;
            data_nx  = shreg;
            valid_nx = 1'b1;
          end else begin
            k_nx   = k + KW'(1);
            sck_nx = 1'b1;
            // Rising entry of k+1 captures B9..B0 for k+1 > null index.
            if (k >= KW'(MCP3002_NULL_IDX))
              shreg_nx = {shreg[MCP3002_DATA_BITS-2:0], dout_r};
          end
        end
      end
      HOLD: begin
        if (half_done) state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mcp3002_sampler.sv
// Self-checking bench: four sampler configurations, each with an MCP3002 pin
// model and a frame-schedule reference model checked every cycle.
module tb_mcp3002_sampler;

  localparam int unsigned CLK_F = 48_000_000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n [4];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int inst, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, inst, $time, act, exp);
    end
  endtask

  // 0: defaults, 1: fast, 2: fast with CHANNEL=1, 3: fast with PERIOD=40.
  function automatic int unsigned sck_of(input int i);
    return (i == 0) ? 800_000 : 12_000_000;
  endfunction
  function automatic int unsigned fs_of(input int i);
    case (i)
      0:       return 48_000;
      3:       return 1_200_000;
      default: return 600_000;
    endcase
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int unsigned SCK = sck_of(gi);
    localparam int unsigned FS  = fs_of(gi);
    localparam int unsigned CH  = (gi == 2) ? 1 : 0;
    localparam int H = int'(CLK_F / (2 * SCK));
    localparam int P = int'(CLK_F / FS);

    bit         dout;
    logic       aclk, din, cs, valid, ovr;
    logic [9:0] sdata;

    mcp3002_sampler #(
      .CLK_FREQ          (CLK_F),
      .MCP3002_CLK_FREQ  (SCK),
      .ADC_SAMPLING_FREQ (FS),
      .CHANNEL           (CH)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n[gi]),
      .adc_dout     (dout),
      .adc_clk      (aclk),
      .adc_din      (din),
      .adc_cs       (cs),
      .sample_data  (sdata),
      .sample_valid (valid),
      .overrun      (ovr)
    );

    // ---------------- MCP3002 pin model ----------------
    logic [9:0] q[$];
    logic [9:0] frame_vals[$];
    logic [9:0] fast_vals [3] = '{10'h000, 10'h3FF, 10'h155};
    logic [9:0] cur = '0;
    int         fc = 0;
    int         din_rec [4];
    int         nrise = 0;

    always @(negedge cs) begin
      if (gi == 0 && frame_vals.size() == 0) cur = 10'h2A5;
      else if (gi == 1 && frame_vals.size() < 3) cur = fast_vals[frame_vals.size()];
      else cur = 10'($urandom);
      frame_vals.push_back(cur);
      q.push_back(cur);
      fc = 0;
    end

    // The ADC shifts on falling SCK: null bit after fall 3, B9..B0 after falls 4..13.
    always @(negedge aclk or posedge cs) begin
      if (cs) dout = 1'($urandom);
      else begin
        if (fc == 3) dout = 1'b1;
        else if (fc >= 4 && fc <= 13) dout = cur[13 - fc];
        else dout = 1'($urandom);
        fc++;
      end
    end

    always @(posedge aclk) begin
      if (nrise < 4) begin
        din_rec[nrise] = din;
        nrise++;
      end
    end

    // ---------------- reference model + compare ----------------
    int         c = 0, fall_c = 0;
    bit         have = 0;
    logic [9:0] exp_data = '0;
    int         nvalid = 0, ncsfall = 0, novr = 0, last_csfall_c = 0;
    int         valid_c [32];
    logic [9:0] valid_d [32];
    int         csfall_c [32];
    int         ovr_c [32];
    logic [9:0] ovr_d [32];
    logic       prev_cs = 1'b1;

    always @(negedge clk) begin
      int f, k, ph, idx;
      bit inf, e_cs, e_sck, e_din, e_val, e_ovr, tk;
      if (!rst_n[gi]) begin
        c = 0; have = 0; exp_data = '0; q.delete();
        chk("rst_cs", gi, cs, 1);
        chk("rst_sck", gi, aclk, 0);
        chk("rst_din", gi, din, 0);
        chk("rst_data", gi, sdata, 0);
        chk("rst_valid", gi, valid, 0);
        chk("rst_ovr", gi, ovr, 0);
      end else begin
        c++;
        f     = c - fall_c;
        inf   = have && (f < 32 * H);
        e_cs  = !(inf && f < 31 * H);
        e_sck = 1'b0;
        e_din = 1'b0;
        if (inf && f < H) e_din = 1'b1;
        else if (inf && f < 31 * H) begin
          k     = (f - H) / (2 * H);
          ph    = (f - H) % (2 * H);
          e_sck = (ph < H);
          idx   = k + (e_sck ? 0 : 1);
          e_din = (idx <= 3) ? ((idx == 2) ? (CH != 0) : 1'b1) : 1'b0;
        end
        e_val = inf && (f == 31 * H);
        if (e_val) begin
          chk("frame_queue", gi, q.size(), 1);
          if (q.size() > 0) exp_data = q.pop_front();
        end
        tk    = (c % P) == 0;
        e_ovr = tk && inf;
        if (tk && !inf) begin
          have   = 1'b1;
          fall_c = c + 1;
        end
        chk("adc_cs", gi, cs, e_cs);
        chk("adc_clk", gi, aclk, e_sck);
        chk("adc_din", gi, din, e_din);
        chk("sample_valid", gi, valid, e_val);
        chk("overrun", gi, ovr, e_ovr);
        chk("sample_data", gi, sdata, exp_data);
        chk("sck_while_cs_high", gi, aclk & cs, 0);
      end
      if (prev_cs && !cs && rst_n[gi]) begin
        if (ncsfall < 32) csfall_c[ncsfall] = c;
        ncsfall++;
        last_csfall_c = c;
      end
      prev_cs = cs;
      if (valid) begin
        if (nvalid < 32) begin valid_c[nvalid] = c; valid_d[nvalid] = sdata; end
        nvalid++;
      end
      if (ovr) begin
        if (novr < 32) begin ovr_c[novr] = c; ovr_d[novr] = sdata; end
        novr++;
      end
    end
  end

  // ---------------- sequence + literal expectations ----------------
  initial begin
    int t, ncs, nv_before;
    for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) rst_n[i] = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;

    t = 0;
    while (g_dut[1].nvalid < 3 && t < 1000) begin @(negedge clk); #1; t++; end
    chk("fast_three_samples_in_time", 1, int'(g_dut[1].nvalid >= 3), 1);

    // Reset inst1 during SHIFT k=7 (frame cycle 30 with HALF=2).
    ncs = g_dut[1].ncsfall;
    t = 0;
    while (g_dut[1].ncsfall == ncs && t < 200) begin @(negedge clk); #1; t++; end
    chk("fast_frame_start_in_time", 1, int'(g_dut[1].ncsfall > ncs), 1);
    repeat (30) @(negedge clk);
    #1;
    nv_before = g_dut[1].nvalid;
    rst_n[1] = 1'b0;
    #1;
    chk("midframe_rst_cs", 1, g_dut[1].cs, 1);
    chk("midframe_rst_sck", 1, g_dut[1].aclk, 0);
    chk("midframe_rst_data", 1, g_dut[1].sdata, 0);
    repeat (3) @(negedge clk);
    #2;
    rst_n[1] = 1'b1;
    ncs = g_dut[1].ncsfall;
    t = 0;
    while (g_dut[1].ncsfall == ncs && t < 300) begin @(negedge clk); #1; t++; end
    chk("restart_in_time", 1, int'(g_dut[1].ncsfall > ncs), 1);
    // Tick at PERIOD=80 after release, CS low from the following edge.
    chk("restart_cs_fall_cycle", 1, g_dut[1].last_csfall_c, 81);
    chk("no_partial_sample", 1, g_dut[1].nvalid, nv_before);

    t = 0;
    while (g_dut[0].nvalid < 10 && t < 12000) begin @(negedge clk); #1; t++; end
    chk("default_ten_frames_in_time", 0, int'(g_dut[0].nvalid >= 10), 1);

    // Defaults: HALF=30, PERIOD=1000, valid 31*HALF=930 cycles after CS falls.
    chk("def_first_cs_fall", 0, g_dut[0].csfall_c[0], 1001);
    chk("def_valid_latency", 0, g_dut[0].valid_c[0] - g_dut[0].csfall_c[0], 930);
    chk("def_data", 0, g_dut[0].valid_d[0], 10'h2A5);
    chk("def_din0", 0, g_dut[0].din_rec[0], 1);
    chk("def_din1", 0, g_dut[0].din_rec[1], 1);
    chk("def_din2", 0, g_dut[0].din_rec[2], 0);
    chk("def_din3", 0, g_dut[0].din_rec[3], 1);

    // Fast: HALF=2, PERIOD=80.
    chk("fast_valid0_cycle", 1, g_dut[1].valid_c[0], 143);
    chk("fast_spacing01", 1, g_dut[1].valid_c[1] - g_dut[1].valid_c[0], 80);
    chk("fast_spacing12", 1, g_dut[1].valid_c[2] - g_dut[1].valid_c[1], 80);
    chk("fast_data0", 1, g_dut[1].valid_d[0], 10'h000);
    chk("fast_data1", 1, g_dut[1].valid_d[1], 10'h3FF);
    chk("fast_data2", 1, g_dut[1].valid_d[2], 10'h155);

    chk("ch1_din2", 2, g_dut[2].din_rec[2], 1);
    chk("ch1_din3", 2, g_dut[2].din_rec[3], 1);

    // PERIOD=40, frame 64: ticks 40 accepted, 80 dropped, 120 accepted, 160 dropped.
    chk("p40_first_overrun", 3, g_dut[3].ovr_c[0], 80);
    chk("p40_first_valid", 3, g_dut[3].valid_c[0], 103);
    chk("p40_second_valid", 3, g_dut[3].valid_c[1], 183);
    chk("p40_second_overrun", 3, g_dut[3].ovr_c[1], 160);
    chk("p40_data_held_at_overrun", 3, g_dut[3].ovr_d[1], g_dut[3].frame_vals[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
